// File: rtl/dmem_store_queue.sv
// In-order store buffer between the core memory stage and the single-port dmem.
// Loads win the dmem port unless they hit a queued word; otherwise the head store drains.
module dmem_store_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     st_byte,
    input  logic                     ld_req,
    input  logic [AW-1:0]            ld_addr,
    input  logic                     ld_byte,
    output logic                     ld_stall,
    output logic                     mem_we,
    output logic                     mem_be,
    output logic [AW-1:0]            mem_a,
    output logic [DW-1:0]            mem_wd,
    output logic                     q_empty,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic          byte_q [DEPTH];
    logic          byte_d [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_match;
    logic             hazard;
    logic             push;
    logic             pop;

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        ent_vld   = '0;
        ent_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i]   = {1'b0, PW'(i) - rd_ptr_q} < count_q;
            ent_match[i] = addr_q[i][AW-1:2] == ld_addr[AW-1:2];
        end
        hazard = ld_req && |(ent_vld & ent_match);
    end

    always_comb begin
        mem_a    = ld_addr;
        mem_be   = ld_byte;
        mem_wd   = '0;
        mem_we   = 1'b0;
        ld_stall = 1'b0;
        pop      = 1'b0;
        if (!reset && !(ld_req && !hazard) && count_q != '0) begin
            mem_a    = addr_q[rd_ptr_q];
            mem_be   = byte_q[rd_ptr_q];
            mem_wd   = data_q[rd_ptr_q];
            mem_we   = 1'b1;
            pop      = 1'b1;
            ld_stall = hazard;
        end
    end

    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
    assign st_ready = reset || (count_q < CW'(DEPTH));
    assign push     = st_valid && st_ready && !reset;
    assign q_empty  = reset || (count_q == '0);
    assign q_count  = reset ? '0 : count_q;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        byte_d   = byte_q;
        if (push) begin
            addr_d[wr_ptr_q] = st_addr;
            data_d[wr_ptr_q] = st_data;
            byte_d[wr_ptr_q] = st_byte;
        end
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        byte_q <= byte_d;
    end
endmodule

// File: tb/tb_dmem_store_queue.sv
// Bench for dmem_store_queue: directed vector table, wrap sequence and random traffic
// checked against a queue-based model of the store buffer.
module tb_dmem_store_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_byte;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          ld_byte;
    logic          ld_stall;
    logic          mem_we;
    logic          mem_be;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          q_empty;
    logic [CW-1:0] q_count;

    always #5 clk = ~clk;

    dmem_store_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_byte(st_byte),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_byte(ld_byte), .ld_stall(ld_stall),
        .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
        .q_empty(q_empty), .q_count(q_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } ent_t;

    typedef struct {
        logic        rst, stv;
        logic [31:0] sta, std;
        logic        stb, ldr;
        logic [31:0] lda;
        logic        ldb;
        logic        x_rdy, x_stall, x_we, x_be;
        logic [31:0] x_a, x_wd;
        int          x_qc;
        logic        x_port;
    } vec_t;

    ent_t mq[$];
    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    logic        e_rdy, e_stall, e_we, e_be;
    logic [31:0] e_a, e_wd;
    int          e_kind;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic stv, input logic [31:0] sta,
                       input logic [31:0] std, input logic stb, input logic ldr,
                       input logic [31:0] lda, input logic ldb, input logic rdy,
                       input logic stall, input logic we, input logic be,
                       input logic [31:0] a, input logic [31:0] wd, input int qc,
                       input logic port);
        vec_t v;
        v = '{rst, stv, sta, std, stb, ldr, lda, ldb, rdy, stall, we, be, a, wd, qc, port};
        vt.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic stv, input logic [31:0] sta,
                         input logic [31:0] std, input logic stb, input logic ldr,
                         input logic [31:0] lda, input logic ldb);
        reset = rst; st_valid = stv; st_addr = sta; st_data = std; st_byte = stb;
        ld_req = ldr; ld_addr = lda; ld_byte = ldb;
    endtask

    // Model: the queue is a plain list of pending stores, oldest first.
    task automatic check_model(input string tag);
        logic haz;
        haz = 1'b0;
        if (reset) begin
            e_rdy = 1'b1; e_stall = 1'b0; e_we = 1'b0; e_kind = 0;
        end else begin
            foreach (mq[k]) if (mq[k].a[31:2] == ld_addr[31:2]) haz = 1'b1;
            haz   = haz && ld_req;
            e_rdy = mq.size() < DEPTH;
            if (ld_req && !haz) begin
                e_kind = 1; e_a = ld_addr; e_be = ld_byte; e_we = 1'b0; e_stall = 1'b0;
            end else if (mq.size() > 0) begin
                e_kind = 2; e_a = mq[0].a; e_be = mq[0].b; e_wd = mq[0].d;
                e_we = 1'b1; e_stall = haz;
            end else begin
                e_kind = 3; e_a = ld_addr; e_be = ld_byte; e_wd = '0;
                e_we = 1'b0; e_stall = 1'b0;
            end
        end
        chk({tag, "_st_ready"}, 32'(st_ready), 32'(e_rdy));
        chk({tag, "_ld_stall"}, 32'(ld_stall), 32'(e_stall));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(e_we));
        chk({tag, "_q_count"}, 32'(q_count), reset ? 32'd0 : 32'(mq.size()));
        chk({tag, "_q_empty"}, 32'(q_empty), (reset || mq.size() == 0) ? 32'd1 : 32'd0);
        if (e_kind != 0) begin
            chk({tag, "_mem_a"}, mem_a, e_a);
            chk({tag, "_mem_be"}, 32'(mem_be), 32'(e_be));
        end
        if (e_kind >= 2) chk({tag, "_mem_wd"}, mem_wd, e_wd);
        if (reset) begin
            mq.delete();
        end else begin
            if (e_we) void'(mq.pop_front());
            if (st_valid && e_rdy) mq.push_back('{st_addr, st_data, st_byte});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, da;
        logic        prev_stall;
        string       nm;
        d0 = 32'h1111_1111; d1 = 32'h2222_2222; d2 = 32'h3333_3333; d3 = 32'h4444_4444;
        d4 = 32'h5555_5555; d5 = 32'h6666_6666; d6 = 32'h7777_7777; d7 = 32'h8888_8888;
        d8 = 32'h9999_9999; da = 32'hAAAA_AAAA;

        // fill to full behind a non-conflicting load, hold a 5th store, then drain in order
        add(1,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,0);
        add(0,1,'h00,d0,0, 1,'h40,0, 1,0,0,0, 'h40,0,0,1);
        add(0,1,'h04,d1,0, 1,'h40,0, 1,0,0,0, 'h40,0,1,1);
        add(0,1,'h08,d2,0, 1,'h40,0, 1,0,0,0, 'h40,0,2,1);
        add(0,1,'h0C,d3,0, 1,'h40,0, 1,0,0,0, 'h40,0,3,1);
        add(0,1,'h10,d4,0, 1,'h40,0, 0,0,0,0, 'h40,0,4,1);
        add(0,1,'h10,d4,0, 1,'h40,0, 0,0,0,0, 'h40,0,4,1);
        add(0,0,0,0,0, 0,0,0,        0,0,1,0, 'h00,d0,4,1);
        add(0,0,0,0,0, 0,0,0,        1,0,1,0, 'h04,d1,3,1);
        add(0,0,0,0,0, 0,0,0,        1,0,1,0, 'h08,d2,2,1);
        add(0,0,0,0,0, 0,0,0,        1,0,1,0, 'h0C,d3,1,1);
        add(0,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,1);
        // byte store then word load to the same word: one stall cycle while it drains
        add(0,1,'h05,'hAB,1, 0,0,0,  1,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 1,'h04,0,     1,1,1,1, 'h05,'hAB,1,1);
        add(0,0,0,0,0, 1,'h04,0,     1,0,0,0, 'h04,0,0,1);
        // unrelated load takes the port; store drains once the load goes away
        add(0,1,'h10,d5,0, 0,0,0,    1,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 1,'h20,0,     1,0,0,0, 'h20,0,1,1);
        add(0,0,0,0,0, 1,'h20,0,     1,0,0,0, 'h20,0,1,1);
        add(0,0,0,0,0, 0,0,0,        1,0,1,0, 'h10,d5,1,1);
        add(0,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,1);
        // push and pop together at count 2
        add(0,1,'h30,d6,0, 1,'h40,0, 1,0,0,0, 'h40,0,0,1);
        add(0,1,'h34,d7,0, 1,'h40,0, 1,0,0,0, 'h40,0,1,1);
        add(0,1,'h38,d8,0, 0,0,0,    1,0,1,0, 'h30,d6,2,1);
        add(0,0,0,0,0, 0,0,0,        1,0,1,0, 'h34,d7,2,1);
        add(0,0,0,0,0, 0,0,0,        1,0,1,0, 'h38,d8,1,1);
        add(0,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,1);
        // reset with three stores pending discards them all
        add(0,1,'h50,da,0, 1,'h40,0, 1,0,0,0, 'h40,0,0,1);
        add(0,1,'h54,da,0, 1,'h40,0, 1,0,0,0, 'h40,0,1,1);
        add(0,1,'h58,da,0, 1,'h40,0, 1,0,0,0, 'h40,0,2,1);
        add(1,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,        1,0,0,0, 0,0,0,1);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].stv, vt[i].sta, vt[i].std, vt[i].stb,
                  vt[i].ldr, vt[i].lda, vt[i].ldb);
            #1;
            nm = $sformatf("v%0d", i);
            chk({nm, "_st_ready"}, 32'(st_ready), 32'(vt[i].x_rdy));
            chk({nm, "_ld_stall"}, 32'(ld_stall), 32'(vt[i].x_stall));
            chk({nm, "_mem_we"}, 32'(mem_we), 32'(vt[i].x_we));
            chk({nm, "_q_count"}, 32'(q_count), 32'(vt[i].x_qc));
            chk({nm, "_q_empty"}, 32'(q_empty), (vt[i].x_qc == 0) ? 32'd1 : 32'd0);
            if (vt[i].x_port) begin
                chk({nm, "_mem_a"}, mem_a, vt[i].x_a);
                chk({nm, "_mem_be"}, 32'(mem_be), 32'(vt[i].x_be));
            end
            if (vt[i].x_we) chk({nm, "_mem_wd"}, mem_wd, vt[i].x_wd);
            check_model({nm, "m"});
            advance();
        end

        // ten back-to-back stores with free drain slots walk both pointers round the ring
        for (int i = 0; i < 13; i++) begin
            if (i < 10) drive(0, 1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            check_model($sformatf("wrap%0d", i));
            advance();
        end

        prev_stall = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!prev_stall) begin
                ld_req  = ($urandom_range(0, 9) < 4);
                ld_addr = 32'($urandom_range(0, 63));
                ld_byte = 1'($urandom_range(0, 1));
            end
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 32'($urandom_range(0, 63));
            st_data  = $urandom;
            st_byte  = 1'($urandom_range(0, 1));
            #1;
            check_model($sformatf("rnd%0d", c));
            prev_stall = e_stall;
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
